// File: rtl/mult_pipe_if.sv
// Operand/result handshake bundle for mult_pipe: operand beat in, result beat out,
// plus the in-flight count. master = producer/consumer side, slave = multiplier.
interface mult_pipe_if #(
    parameter int BIT_SZ = 8,
    parameter int STAGES = 3
);
    localparam int OCC_W = $clog2(STAGES + 1);

    logic              in_vld;
    logic              in_rdy;
    logic [BIT_SZ-1:0] a;
    logic [BIT_SZ-1:0] b;
    logic              sgn;
    logic [1:0]        mode;
    logic              out_vld;
    logic              out_rdy;
    logic [BIT_SZ-1:0] y;
    logic              ovf;
    logic [OCC_W-1:0]  occ;

    modport master (
        output in_vld, a, b, sgn, mode, out_rdy,
        input  in_rdy, out_vld, y, ovf, occ
    );

    modport slave (
        input  in_vld, a, b, sgn, mode, out_rdy,
        output in_rdy, out_vld, y, ovf, occ
    );
endinterface

// File: rtl/mult_pipe.sv
// Pipelined BIT_SZ x BIT_SZ multiplier with bubble-collapsing valid/ready flow control,
// signed/unsigned operands and wrap / high-half / saturate result modes.
module mult_pipe #(
    parameter int BIT_SZ = 8,
    parameter int STAGES = 3
) (
    input  logic        clk,
    input  logic        rst_l,
    mult_pipe_if.slave  bus
);
    localparam int W2    = 2 * BIT_SZ;
    localparam int OCC_W = $clog2(STAGES + 1);
    localparam int LAST  = STAGES - 1;

    typedef struct packed {
        logic [W2-1:0] p;
        logic          sgn;
        logic [1:0]    mode;
    } beat_t;

    function automatic logic [W2-1:0] full_product(
        input logic [BIT_SZ-1:0] op_a,
        input logic [BIT_SZ-1:0] op_b,
        input logic              is_sgn
    );
        logic [W2-1:0] ax;
        logic [W2-1:0] bx;
        ax = {{BIT_SZ{is_sgn & op_a[BIT_SZ-1]}}, op_a};
        bx = {{BIT_SZ{is_sgn & op_b[BIT_SZ-1]}}, op_b};
        return ax * bx;
    endfunction

    // Returns {ovf, y}; a signed product fits only if its top BIT_SZ+1 bits agree.
    function automatic logic [BIT_SZ:0] shape_result(input beat_t bt);
        logic [BIT_SZ-1:0] hi;
        logic [BIT_SZ-1:0] lo;
        logic [BIT_SZ:0]   top;
        logic [BIT_SZ-1:0] y_v;
        logic              ovf_v;
        hi  = bt.p[W2-1:BIT_SZ];
        lo  = bt.p[BIT_SZ-1:0];
        top = bt.p[W2-1:BIT_SZ-1];
        if (bt.sgn) begin
            ovf_v = ~((&top) | ~(|top));
        end else begin
            ovf_v = |hi;
        end
        case (bt.mode)
            2'b01: begin
                y_v   = hi;
                ovf_v = 1'b0;
            end
            2'b10: begin
                if (!ovf_v) begin
                    y_v = lo;
                end else if (bt.sgn) begin
                    y_v = {bt.p[W2-1], {(BIT_SZ-1){~bt.p[W2-1]}}};
                end else begin
                    y_v = {BIT_SZ{1'b1}};
                end
            end
            default: begin
                y_v = lo;
            end
        endcase
        return {ovf_v, y_v};
    endfunction

    logic [STAGES-1:0] vld_r;
    logic [STAGES-1:0] adv_s;
    logic [STAGES-1:0] load_s;
    logic [STAGES-1:0] vld_in_s;
    logic [OCC_W-1:0]  occ_r;
    logic [BIT_SZ-1:0] y_r;
    logic              ovf_r;
    logic              in_xfer_s;
    logic              out_xfer_s;
    beat_t             in_beat_s;
    beat_t             last_beat_s;

    // Advance chain from the output back: a slot moves when the slot ahead is free or moving.
    always_comb begin
        logic go_v;
        adv_s       = '0;
        go_v        = vld_r[LAST] & bus.out_rdy;
        adv_s[LAST] = go_v;
        for (int k = STAGES - 2; k >= 0; k--) begin
            go_v     = vld_r[k] & (~vld_r[k+1] | go_v);
            adv_s[k] = go_v;
        end
    end

    assign load_s     = ~vld_r | adv_s;
    assign bus.in_rdy = rst_l & load_s[0];
    assign in_xfer_s  = bus.in_vld & bus.in_rdy;
    assign out_xfer_s = vld_r[LAST] & bus.out_rdy;
    assign vld_in_s   = (vld_r << 1'b1) | STAGES'(in_xfer_s);
    assign in_beat_s  = {full_product(bus.a, bus.b, bus.sgn), bus.sgn, bus.mode};

    // Slot valid bits: a loading slot takes the valid of the slot behind it (or the input).
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            vld_r <= '0;
        end else begin
            vld_r <= (vld_r & ~load_s) | (vld_in_s & load_s);
        end
    end

    // In-flight count tracks input and output transfers.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            occ_r <= '0;
        end else begin
            case ({in_xfer_s, out_xfer_s})
                2'b10:   occ_r <= occ_r + OCC_W'(1);
                2'b01:   occ_r <= occ_r - OCC_W'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    generate
        if (STAGES > 1) begin : g_pipe
            beat_t beat_r [STAGES-1];

            // Product slots ahead of the result slot; data moves only with a valid beat.
            always_ff @(posedge clk or negedge rst_l) begin
                if (!rst_l) begin
                    for (int k = 0; k < STAGES - 1; k++) begin
                        beat_r[k] <= '0;
                    end
                end else begin
                    if (load_s[0] & in_xfer_s) begin
                        beat_r[0] <= in_beat_s;
                    end
                    for (int k = 1; k < STAGES - 1; k++) begin
                        if (load_s[k] & vld_r[k-1]) begin
                            beat_r[k] <= beat_r[k-1];
                        end
                    end
                end
            end

            assign last_beat_s = beat_r[STAGES-2];
        end else begin : g_direct
            assign last_beat_s = in_beat_s;
        end
    endgenerate

    // Result slot holds the shaped y/ovf so the outputs are pure register outputs.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            y_r   <= '0;
            ovf_r <= 1'b0;
        end else if (load_s[LAST] & vld_in_s[LAST]) begin
            {ovf_r, y_r} <= shape_result(last_beat_s);
        end else begin
            y_r   <= y_r;
            ovf_r <= ovf_r;
        end
    end

    assign bus.out_vld = vld_r[LAST];
    assign bus.y       = y_r;
    assign bus.ovf     = ovf_r;
    assign bus.occ     = occ_r;
endmodule

// File: tb/tb_mult_pipe.sv
// Self-checking bench for mult_pipe (BIT_SZ=8, STAGES=3): vector table, scoreboard
// queue filled on input transfer and drained on output transfer, plus flow-control sequences.
module tb_mult_pipe;
    localparam int B = 8;
    localparam int S = 3;

    logic clk   = 1'b0;
    logic rst_l = 1'b0;

    mult_pipe_if #(.BIT_SZ(B), .STAGES(S)) bus ();

    mult_pipe #(.BIT_SZ(B), .STAGES(S)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sgn;
        logic [1:0] mode;
        logic [7:0] y;
        logic       ovf;
    } vec_t;

    vec_t       tbl [18];
    logic [8:0] sb_q [$];
    int         total = 0;
    int         bad   = 0;
    int         exp_occ = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Independent reference using integer arithmetic and range tests.
    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic s, input logic [1:0] m);
        int         pa;
        int         pb;
        int         p;
        logic [15:0] pv;
        logic       ov;
        logic [7:0] yy;
        pa = s ? int'($signed(a)) : int'(a);
        pb = s ? int'($signed(b)) : int'(b);
        p  = pa * pb;
        pv = p[15:0];
        ov = s ? (p < -128 || p > 127) : (p > 255);
        case (m)
            2'b01: begin
                yy = pv[15:8];
                ov = 1'b0;
            end
            2'b10: yy = !ov ? pv[7:0] : (!s ? 8'hFF : (p < 0 ? 8'h80 : 8'h7F));
            default: yy = pv[7:0];
        endcase
        return {ov, yy};
    endfunction

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [1:0] m, input logic [8:0] e);
        int   n;
        logic acc;
        bus.a = a; bus.b = b; bus.sgn = s; bus.mode = m; bus.in_vld = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            if (bus.in_rdy) begin
                acc = 1'b1;
                sb_q.push_back(e);
            end
            @(posedge clk); #1;
            n++;
        end
        bus.in_vld = 1'b0;
        if (!acc) begin
            total++; bad++;
            $display("FAIL send_timeout: got no in_rdy expected in_rdy within 200 cycles");
        end
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic set_bp_beat(input int i);
        bus.a    = 8'(17 * (i + 1));
        bus.b    = 8'(3 + i);
        bus.sgn  = (i % 2) == 1;
        bus.mode = 2'(i % 3);
    endtask

    // Output monitor: scoreboard pop on output transfer, hold check while stalled, occ tracking.
    initial begin
        logic       held;
        logic [7:0] held_y;
        logic [8:0] e;
        held = 1'b0;
        held_y = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_l) begin
                exp_occ = 0;
                held    = 1'b0;
            end
            chk("occ", 32'(bus.occ), 32'(exp_occ));
            if (rst_l) begin
                if (held && bus.out_vld) chk("y_hold", 32'(bus.y), 32'(held_y));
                if (bus.out_vld && bus.out_rdy) begin
                    if (sb_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_out: got y=%0h expected no result", bus.y);
                    end else begin
                        e = sb_q.pop_front();
                        chk("y", 32'(bus.y), 32'(e[7:0]));
                        chk("ovf", 32'(bus.ovf), 32'(e[8]));
                    end
                end
                held   = bus.out_vld & ~bus.out_rdy;
                held_y = bus.y;
                exp_occ = exp_occ + int'(bus.in_vld & bus.in_rdy) - int'(bus.out_vld & bus.out_rdy);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int stale;
        bus.in_vld = 1'b0; bus.a = 8'h00; bus.b = 8'h00;
        bus.sgn = 1'b0; bus.mode = 2'b00; bus.out_rdy = 1'b1;

        tbl[0]  = '{8'h0C, 8'h0B, 1'b0, 2'b00, 8'h84, 1'b0};
        tbl[1]  = '{8'hFF, 8'hFF, 1'b0, 2'b00, 8'h01, 1'b1};
        tbl[2]  = '{8'hFF, 8'hFF, 1'b0, 2'b01, 8'hFE, 1'b0};
        tbl[3]  = '{8'hFF, 8'hFF, 1'b0, 2'b10, 8'hFF, 1'b1};
        tbl[4]  = '{8'h80, 8'h80, 1'b1, 2'b00, 8'h00, 1'b1};
        tbl[5]  = '{8'h80, 8'h80, 1'b1, 2'b01, 8'h40, 1'b0};
        tbl[6]  = '{8'h80, 8'h80, 1'b1, 2'b10, 8'h7F, 1'b1};
        tbl[7]  = '{8'h80, 8'h02, 1'b1, 2'b10, 8'h80, 1'b1};
        tbl[8]  = '{8'hFE, 8'h03, 1'b1, 2'b10, 8'hFA, 1'b0};
        tbl[9]  = '{8'h10, 8'h11, 1'b0, 2'b11, 8'h10, 1'b1};
        tbl[10] = '{8'hFF, 8'hFF, 1'b1, 2'b01, 8'h00, 1'b0};
        tbl[11] = '{8'h7F, 8'h7F, 1'b1, 2'b10, 8'h7F, 1'b1};
        tbl[12] = '{8'h7F, 8'h7F, 1'b1, 2'b01, 8'h3F, 1'b0};
        tbl[13] = '{8'h80, 8'h01, 1'b1, 2'b10, 8'h80, 1'b0};
        tbl[14] = '{8'hF0, 8'h09, 1'b1, 2'b00, 8'h70, 1'b1};
        tbl[15] = '{8'hF0, 8'h09, 1'b1, 2'b01, 8'hFF, 1'b0};
        tbl[16] = '{8'h10, 8'h10, 1'b0, 2'b10, 8'hFF, 1'b1};
        tbl[17] = '{8'h0F, 8'h11, 1'b0, 2'b10, 8'hFF, 1'b0};

        #2;
        chk("rst_out_vld", 32'(bus.out_vld), 32'd0);
        chk("rst_y", 32'(bus.y), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        chk("rst_occ", 32'(bus.occ), 32'd0);
        chk("rst_in_rdy", 32'(bus.in_rdy), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_l = 1'b1;
        @(negedge clk);
        chk("release_in_rdy", 32'(bus.in_rdy), 32'd1);
        @(posedge clk); #1;

        // Latency: one beat, out_vld on the third cycle after acceptance.
        send(tbl[0].a, tbl[0].b, tbl[0].sgn, tbl[0].mode, {tbl[0].ovf, tbl[0].y});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("lat_occ", 32'(bus.occ), (k < 3) ? 32'd1 : 32'd0);
            chk("lat_out_vld", 32'(bus.out_vld), (k == 2) ? 32'd1 : 32'd0);
        end
        @(posedge clk); #1;

        // Table vectors, streamed back to back.
        for (int i = 0; i < 18; i++) begin
            send(tbl[i].a, tbl[i].b, tbl[i].sgn, tbl[i].mode, {tbl[i].ovf, tbl[i].y});
        end
        wait_empty();

        // Backpressure: five beats offered into a stalled pipe.
        bus.out_rdy = 1'b0;
        idx = 0;
        set_bp_beat(0);
        bus.in_vld = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (bus.in_rdy) begin
                sb_q.push_back(model(bus.a, bus.b, bus.sgn, bus.mode));
                idx++;
            end
            @(posedge clk); #1;
            set_bp_beat(idx);
        end
        chk("bp_accepted", 32'(idx), 32'd3);
        @(negedge clk);
        chk("bp_in_rdy_full", 32'(bus.in_rdy), 32'd0);
        chk("bp_occ_full", 32'(bus.occ), 32'd3);
        chk("bp_out_vld", 32'(bus.out_vld), 32'd1);
        @(posedge clk); #1;
        bus.out_rdy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_no_gap", 32'(bus.out_vld), 32'd1);
            if (c == 0) chk("bp_rdy_same_cycle", 32'(bus.in_rdy), 32'd1);
            if (bus.in_vld && bus.in_rdy) begin
                sb_q.push_back(model(bus.a, bus.b, bus.sgn, bus.mode));
                idx++;
            end
            @(posedge clk); #1;
            if (idx < 5) set_bp_beat(idx);
            else bus.in_vld = 1'b0;
        end
        chk("bp_all_accepted", 32'(idx), 32'd5);
        wait_empty();

        // Bubble collapse: beats two cycles apart under stall end up adjacent.
        bus.out_rdy = 1'b0;
        send(8'h05, 8'h07, 1'b0, 2'b00, model(8'h05, 8'h07, 1'b0, 2'b00));
        @(posedge clk); #1;
        send(8'hF9, 8'h06, 1'b1, 2'b10, model(8'hF9, 8'h06, 1'b1, 2'b10));
        @(posedge clk); #1;
        @(negedge clk);
        chk("bub_occ", 32'(bus.occ), 32'd2);
        chk("bub_in_rdy", 32'(bus.in_rdy), 32'd1);
        @(posedge clk); #1;
        bus.out_rdy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bub_out_vld", 32'(bus.out_vld), (c < 2) ? 32'd1 : 32'd0);
        end
        @(posedge clk); #1;

        // Random traffic with random consumer stalls.
        idx = 0;
        for (int n = 0; n < 400 && idx < 40; n++) begin
            if (!bus.in_vld) begin
                bus.a = 8'($urandom_range(0, 255));
                bus.b = 8'($urandom_range(0, 255));
                bus.sgn = 1'($urandom_range(0, 1));
                bus.mode = 2'($urandom_range(0, 3));
                bus.in_vld = 1'b1;
            end
            bus.out_rdy = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.in_rdy) begin
                sb_q.push_back(model(bus.a, bus.b, bus.sgn, bus.mode));
                idx++;
            end
            @(posedge clk); #1;
            if (sb_q.size() > 0 && bus.in_rdy == 1'b0) begin
                bus.in_vld = bus.in_vld;
            end else begin
                bus.in_vld = 1'b0;
            end
        end
        bus.in_vld = 1'b0;
        bus.out_rdy = 1'b1;
        chk("rand_count", 32'(idx), 32'd40);
        wait_empty();

        // Mid-stream reset discards in-flight beats immediately.
        bus.out_rdy = 1'b0;
        send(8'h03, 8'h05, 1'b0, 2'b00, model(8'h03, 8'h05, 1'b0, 2'b00));
        send(8'h09, 8'h09, 1'b0, 2'b00, model(8'h09, 8'h09, 1'b0, 2'b00));
        send(8'hFD, 8'h04, 1'b1, 2'b00, model(8'hFD, 8'h04, 1'b1, 2'b00));
        @(negedge clk);
        chk("mr_pre_out_vld", 32'(bus.out_vld), 32'd1);
        @(posedge clk); #1;
        rst_l = 1'b0;
        sb_q.delete();
        #1;
        chk("mr_out_vld", 32'(bus.out_vld), 32'd0);
        chk("mr_y", 32'(bus.y), 32'd0);
        chk("mr_ovf", 32'(bus.ovf), 32'd0);
        chk("mr_occ", 32'(bus.occ), 32'd0);
        chk("mr_in_rdy", 32'(bus.in_rdy), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_l = 1'b1;
        bus.out_rdy = 1'b1;
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.out_vld) stale++;
        end
        chk("mr_no_stale", 32'(stale), 32'd0);
        @(posedge clk); #1;
        send(8'h0A, 8'h0A, 1'b0, 2'b10, 9'h064);
        wait_empty();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
